// File: rtl/pio_cmd_pkg.sv
// Shared types and field positions for the HPS PIO command channel:
// opcodes, responder FSM states and command/response bit layout.
package pio_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_CLR  = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Command word layout
  localparam int CMD_TGL     = 31;
  localparam int CMD_OP_HI   = 30;
  localparam int CMD_OP_LO   = 29;
  localparam int CMD_ADDR_HI = 23;
  localparam int CMD_ADDR_LO = 16;
  localparam int CMD_WDATA_HI = 15;
  localparam int CMD_WDATA_LO = 0;

  // Response word layout
  localparam int RSP_TGL     = 31;
  localparam int RSP_BUSY    = 30;
  localparam int RSP_ERR     = 29;
  localparam int RSP_ADDR_LO = 16;

endpackage

// File: rtl/pio_cmd_responder_if.sv
// PIO command/response bundle between the HPS-side PIO exports and the
// responder, plus the responder's status and FSM state for observation.
//
// Handshake: a request is pending while pio_out_word[31] != pio_in_word[31];
// the responder acknowledges by copying the request toggle into the response.
interface pio_cmd_responder_if;
  import pio_cmd_pkg::*;

  logic [31:0] pio_out_word;
  logic [31:0] pio_in_word;
  logic        busy;
  logic [15:0] cmd_count;
  state_e      state;

  modport master (
    output pio_out_word,
    input  pio_in_word, busy, cmd_count, state
  );

  modport slave (
    input  pio_out_word,
    output pio_in_word, busy, cmd_count, state
  );

endinterface

// File: rtl/pio_cmd_regbank.sv
// Single-port register bank: synchronous write, registered read.
// Contents are deliberately not reset.
module pio_cmd_regbank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 200
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pio_cmd_responder.sv
// Fabric-side responder for the HPS PIO command channel: decodes a command
// word, executes it on a local register bank and returns a toggle-acked response.
module pio_cmd_responder
  import pio_cmd_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 200
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  pio_cmd_responder_if.slave   pio
);

  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

  state_e            state, state_nxt;
  logic [31:0]       cmd_q;
  logic [31:0]       resp_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] clr_ptr;
  logic              err_q;

  op_e               cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              exec_err;
  logic              new_req;
  logic              busy_w;

  logic              bank_we, bank_re;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata, bank_rdata;
  logic [15:0]       rdata_field;
  logic [31:0]       resp_nxt;
  logic              unused_cmd_bits;

  assign cmd_op   = op_e'(cmd_q[CMD_OP_HI:CMD_OP_LO]);
  assign cmd_addr = cmd_q[CMD_ADDR_LO +: ADDR_W];
  assign exec_err = ({1'b0, cmd_addr} >= DEPTH_LIM) &&
                    (cmd_op == OP_WRITE || cmd_op == OP_READ);
  assign new_req  = pio.pio_out_word[CMD_TGL] != resp_q[RSP_TGL];
  assign busy_w   = state != ST_IDLE;
  assign unused_cmd_bits = ^{cmd_q[28:24], cmd_q[CMD_WDATA_HI:CMD_WDATA_LO]};

  pio_cmd_regbank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk   (clk_clk),
    .we    (bank_we),
    .re    (bank_re),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  always_comb begin
    state_nxt  = state;
    bank_we    = 1'b0;
    bank_re    = 1'b0;
    bank_addr  = cmd_addr;
    bank_wdata = cmd_q[CMD_WDATA_LO +: DATA_W];
    case (state)
      ST_IDLE: begin
        if (new_req) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = (cmd_op == OP_CLEAR) ? ST_CLR : ST_RESP;
        if (!exec_err) begin
          bank_we = (cmd_op == OP_WRITE);
          bank_re = (cmd_op == OP_READ);
        end
      end
      ST_CLR: begin
        bank_we    = 1'b1;
        bank_addr  = clr_ptr;
        bank_wdata = '0;
        if (clr_ptr == CLR_LAST) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Only a successful READ returns bank data; everything else answers zero.
  always_comb begin
    rdata_field = '0;
    if (cmd_op == OP_READ && !err_q) begin
      rdata_field[DATA_W-1:0] = bank_rdata;
    end
    resp_nxt = {cmd_q[CMD_TGL], 1'b0, err_q, 5'b0,
                cmd_q[CMD_ADDR_HI:CMD_ADDR_LO], rdata_field};
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      resp_q  <= '0;
      count_q <= '0;
      clr_ptr <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (new_req) cmd_q <= pio.pio_out_word;
        end
        ST_EXEC: begin
          err_q   <= exec_err;
          clr_ptr <= '0;
        end
        ST_CLR: begin
          clr_ptr <= clr_ptr + 1'b1;
        end
        ST_RESP: begin
          resp_q  <= resp_nxt;
          count_q <= count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Busy bit is live while a command is in flight; other fields hold.
  assign pio.pio_in_word = {resp_q[RSP_TGL], busy_w, resp_q[RSP_ERR:0]};
  assign pio.busy        = busy_w;
  assign pio.cmd_count   = count_q;
  assign pio.state       = state;

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Directed bench for pio_cmd_responder: drivers issue commands and push the
// expected response; a monitor checks each acknowledged response in order.
module tb_pio_cmd_responder;
  import pio_cmd_pkg::*;

  localparam int DEPTH  = 200;
  localparam int BUDGET = 600;

  logic clk_clk;
  logic reset_reset;

  pio_cmd_responder_if pio();

  pio_cmd_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .pio         (pio.slave)
  );

  // clock / reset
  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        tgl = 1'b0;
  logic        prev_ack = 1'b0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] exp_q[$];
  logic [15:0] cnt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [1:0] op, input logic [7:0] addr,
                       input logic [15:0] wd, input logic [30:0] body);
    tgl = ~tgl;
    pio.pio_out_word = {tgl, op, 5'b0, addr, wd};
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back({tgl, body});
    cnt_q.push_back(exp_cnt);
  endtask

  task automatic wait_ack(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (pio.pio_in_word[31] !== tgl && lat < BUDGET) begin
      @(negedge clk_clk);
      lat++;
      if (pio.busy) busy_n++;
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [7:0] addr,
                     input logic [15:0] wd, input logic [30:0] body, input int exp_lat);
    int lat, busy_n;
    issue(op, addr, wd, body);
    wait_ack(lat, busy_n);
    check({name, "_latency"}, lat, exp_lat);
  endtask

  // scoreboard monitor
  always @(negedge clk_clk) begin
    if (mon_en && pio.pio_in_word[31] !== prev_ack) begin
      prev_ack = pio.pio_in_word[31];
      if (exp_q.size() == 0) begin
        check("unexpected_response", pio.pio_in_word, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        logic [15:0] c;
        e = exp_q.pop_front();
        c = cnt_q.pop_front();
        check("response", pio.pio_in_word, e);
        check("cmd_count", {16'h0, pio.cmd_count}, {16'h0, c});
      end
    end
  end

  initial begin
    int lat, busy_n, clr_at, wr_at;
    logic last;

    reset_reset = 1'b1;
    pio.pio_out_word = 32'h0;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset = 1'b0;

    // idle after reset with pio_out held at zero
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_clk);
      check("idle_word", pio.pio_in_word, 32'h0);
      check("idle_busy_count", {15'h0, pio.busy, pio.cmd_count}, 32'h0);
    end
    mon_en = 1'b1;

    run("wr05",   OP_WRITE, 8'h05, 16'hBEEF, 31'h0005_0000, 3);
    run("rd05",   OP_READ,  8'h05, 16'h0000, 31'h0005_BEEF, 3);
    run("rdC8",   OP_READ,  8'hC8, 16'h0000, 31'h20C8_0000, 3);
    run("rd05b",  OP_READ,  8'h05, 16'h0000, 31'h0005_BEEF, 3);
    run("wrC7",   OP_WRITE, 8'hC7, 16'h5A5A, 31'h00C7_0000, 3);
    run("wr00",   OP_WRITE, 8'h00, 16'h1111, 31'h0000_0000, 3);
    run("wrC8",   OP_WRITE, 8'hC8, 16'h7777, 31'h20C8_0000, 3);

    // CLEAR: full sweep, busy for DEPTH+2 cycles
    issue(OP_CLEAR, 8'h33, 16'h0000, 31'h0033_0000);
    wait_ack(lat, busy_n);
    check("clear_latency", lat, 3 + DEPTH);
    check("clear_busy_cycles", busy_n, DEPTH + 2);
    run("rd00_clr", OP_READ, 8'h00, 16'h0000, 31'h0000_0000, 3);
    run("rd05_clr", OP_READ, 8'h05, 16'h0000, 31'h0005_0000, 3);
    run("rdC7_clr", OP_READ, 8'hC7, 16'h0000, 31'h00C7_0000, 3);

    // request arriving mid-CLEAR is taken right after the CLEAR response
    issue(OP_CLEAR, 8'h00, 16'h0000, 31'h0000_0000);
    repeat (30) @(negedge clk_clk);
    check("clr_busy_bit", {31'h0, pio.pio_in_word[30]}, 32'h1);
    check("clr_state", {30'h0, pio.state}, {30'h0, ST_CLR});
    last = pio.pio_in_word[31];
    issue(OP_WRITE, 8'h10, 16'h1234, 31'h0010_0000);
    lat = 0; clr_at = -1; wr_at = -1;
    while (wr_at < 0 && lat < BUDGET) begin
      @(negedge clk_clk);
      lat++;
      if (pio.pio_in_word[31] !== last) begin
        last = pio.pio_in_word[31];
        if (clr_at < 0) clr_at = lat;
        else wr_at = lat;
      end
    end
    check("queued_write_gap", wr_at - clr_at, 3);
    run("rd10", OP_READ, 8'h10, 16'h0000, 31'h0010_1234, 3);
    run("nop22", OP_NOP, 8'h22, 16'hFFFF, 31'h0022_0000, 3);

    // pio_out changing after the command is latched must not matter
    issue(OP_WRITE, 8'h06, 16'hAAAA, 31'h0006_0000);
    @(negedge clk_clk);
    pio.pio_out_word[15:0] = 16'h5555;
    wait_ack(lat, busy_n);
    check("wr06_latency", lat + 1, 3);
    run("rd06", OP_READ, 8'h06, 16'h0000, 31'h0006_AAAA, 3);

    repeat (4) @(negedge clk_clk);
    check("queue_drained", exp_q.size(), 0);

    // reset in the middle of a CLEAR sweep
    tgl = ~tgl;
    pio.pio_out_word = {tgl, OP_CLEAR, 5'b0, 8'h00, 16'h0000};
    repeat (52) @(negedge clk_clk);
    check("pre_reset_state", {30'h0, pio.state}, {30'h0, ST_CLR});
    mon_en = 1'b0;
    reset_reset = 1'b1;
    pio.pio_out_word = 32'h0;
    @(negedge clk_clk);
    check("rst_word", pio.pio_in_word, 32'h0);
    check("rst_busy", {31'h0, pio.busy}, 32'h0);
    check("rst_state", {30'h0, pio.state}, {30'h0, ST_IDLE});
    check("rst_count", {16'h0, pio.cmd_count}, 32'h0);
    reset_reset = 1'b0;
    tgl = 1'b0;
    prev_ack = 1'b0;
    exp_cnt = 16'd0;
    mon_en = 1'b1;
    @(negedge clk_clk);
    run("nop_after_rst", OP_NOP, 8'h00, 16'h0000, 31'h0000_0000, 3);

    repeat (4) @(negedge clk_clk);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
